// File: rtl/sad_pkg.sv
// ---------------------------------------------------------------------------
// sad_pkg
// Shared definitions for the SAD datapath (sad_window_feeder and compute_SAD).
// Holds default geometry, derived widths and the window feeder state enum.
// ---------------------------------------------------------------------------
package sad_pkg;

    localparam int WIN_DEF       = 15;
    localparam int DATA_SIZE_DEF = 8;
    localparam int IMG_W_DEF     = 1;
    localparam int MAX_DISP_DEF  = 64;

    localparam int BEAT_W_DEF    = DATA_SIZE_DEF * IMG_W_DEF;
    localparam int OUT_WIDTH_DEF = BEAT_W_DEF * WIN_DEF;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

    // Width of a counter that must hold values 0..win inclusive.
    function automatic int cnt_width(input int win);
        return (win < 1) ? 1 : $clog2(win + 1);
    endfunction

endpackage

// File: rtl/sad_window_shreg.sv
// ---------------------------------------------------------------------------
// sad_window_shreg
// WIN-slot shift register of BEAT_W-bit beats, exposed as one flat bus.
// A shifted beat enters slot WIN-1 and every slot moves down by one, so
// slot 0 always holds the oldest beat.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset, clears every slot
//   i_en    in   shift i_data in
//   i_clr   in   with i_en: load i_data into slot WIN-1 and zero the rest;
//                alone: zero every slot
//   i_data  in   beat to shift in
//   o_flat  out  slot k at bits [k*BEAT_W +: BEAT_W]
// ---------------------------------------------------------------------------
module sad_window_shreg #(
    parameter int WIN    = 15,
    parameter int BEAT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [BEAT_W-1:0]     i_data,
    output logic [WIN*BEAT_W-1:0] o_flat
);

    // Packed so that element k lands at bits [k*BEAT_W +: BEAT_W] of o_flat.
    logic [WIN-1:0][BEAT_W-1:0] r_slots;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slots <= '0;
        end else if (i_en && i_clr) begin
            // Start of a fresh row: history is dropped in the same edge the
            // first beat arrives, so a still-pending window is untouched.
            r_slots <= {i_data, {((WIN-1)*BEAT_W){1'b0}}};
        end else if (i_en) begin
            r_slots <= {i_data, r_slots[WIN-1:1]};
        end else if (i_clr) begin
            r_slots <= '0;
        end
    end

    assign o_flat = r_slots;

endmodule

// File: rtl/sad_window_feeder.sv
// ---------------------------------------------------------------------------
// sad_window_feeder
// Turns a row-ordered pixel beat stream into sliding windows of WIN beats
// for compute_SAD. Windows never cross a row boundary (s_last).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   s_valid    in   input beat valid
//   s_ready    out  feeder can accept a beat (!m_valid || m_ready)
//   s_data     in   pixel beat, lane j at [j*DATA_SIZE +: DATA_SIZE]
//   s_last     in   beat is the last of its row
//   m_valid    out  window valid
//   m_ready    in   consumer accepts the window
//   m_window   out  window, slot k (0 = oldest) at [k*BEAT_W +: BEAT_W]
//   short_row  out  one-cycle pulse: row ended before WIN beats arrived
//
// Build option SAD_FEEDER_ZERO_PAD_EN: each row is padded with WIN/2 zero
// beats on both sides (DRAIN state), giving one window per input beat.
// ---------------------------------------------------------------------------
module sad_window_feeder
    import sad_pkg::*;
#(
    parameter int WIN       = WIN_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int IMG_W     = IMG_W_DEF,
    parameter int BEAT_W    = DATA_SIZE * IMG_W,
    parameter int OUT_WIDTH = DATA_SIZE * IMG_W * WIN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [BEAT_W-1:0]    s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_window,
    output logic                 short_row
);

    localparam int            CW    = cnt_width(WIN);
    localparam logic [CW-1:0] WIN_C = CW'(WIN);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    feeder_state_e    r_state;
    feeder_state_e    w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_cnt_base;
    logic [CW-1:0]    w_cnt_inc;
    logic             r_m_valid;
    logic             w_m_valid_nxt;
    logic             r_short;
    logic             w_short_nxt;

    logic             w_out_free;
    logic             w_acc;
    logic             w_shift;
    logic             w_full;
    logic             w_clr;
    logic [BEAT_W-1:0] w_shift_data;

`ifdef SAD_FEEDER_ZERO_PAD_EN
    localparam int            PRE   = WIN / 2;
    localparam logic [CW-1:0] PRE_C = CW'(PRE);

    logic             r_row_start;
    logic             w_row_start_nxt;
    logic [CW-1:0]    r_drain;
    logic [CW-1:0]    w_drain_nxt;
    logic             w_drain_shift;
`endif

    // ---------------------------------------------------------------
    // Handshake and shift control
    // ---------------------------------------------------------------
    assign w_out_free = !r_m_valid || m_ready;

`ifdef SAD_FEEDER_ZERO_PAD_EN
    assign s_ready       = w_out_free && (r_state != DRAIN);
    assign w_drain_shift = (r_state == DRAIN) && w_out_free;
    assign w_shift       = w_acc || w_drain_shift;
    assign w_shift_data  = (r_state == DRAIN) ? '0 : s_data;
    // The row-start zero preload is folded into the first beat's shift.
    assign w_clr         = r_row_start && w_acc;
    assign w_cnt_base    = r_row_start ? PRE_C : r_cnt;
`else
    assign s_ready       = w_out_free;
    assign w_shift       = w_acc;
    assign w_shift_data  = s_data;
    assign w_clr         = 1'b0;
    assign w_cnt_base    = r_cnt;
`endif

    assign w_acc = s_valid && s_ready;

    // Saturate at WIN so a 2^n-1 window length never wraps the counter.
    assign w_cnt_inc = (w_cnt_base == WIN_C) ? WIN_C : (w_cnt_base + ONE_C);
    assign w_full    = (w_cnt_inc == WIN_C);

    sad_window_shreg #(
        .WIN    (WIN),
        .BEAT_W (BEAT_W)
    ) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_shift),
        .i_clr  (w_clr),
        .i_data (w_shift_data),
        .o_flat (m_window)
    );

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_short_nxt   = 1'b0;
        // A held window survives until consumed; a fresh one overrides.
        w_m_valid_nxt = r_m_valid && !m_ready;
`ifdef SAD_FEEDER_ZERO_PAD_EN
        w_row_start_nxt = r_row_start;
        w_drain_nxt     = r_drain;
`endif

        if (w_shift && w_full) begin
            w_m_valid_nxt = 1'b1;
        end

        case (r_state)
            FILL, STREAM: begin
                if (w_acc) begin
`ifdef SAD_FEEDER_ZERO_PAD_EN
                    w_row_start_nxt = 1'b0;
                    if (s_last) begin
                        if (PRE == 0) begin
                            w_state_nxt     = FILL;
                            w_cnt_nxt       = '0;
                            w_row_start_nxt = 1'b1;
                        end else begin
                            w_state_nxt = DRAIN;
                            w_cnt_nxt   = w_cnt_inc;
                            w_drain_nxt = '0;
                        end
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = w_full ? STREAM : FILL;
                    end
`else
                    if (s_last) begin
                        w_state_nxt = FILL;
                        w_cnt_nxt   = '0;
                        w_short_nxt = !w_full;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = w_full ? STREAM : FILL;
                    end
`endif
                end
            end
`ifdef SAD_FEEDER_ZERO_PAD_EN
            DRAIN: begin
                if (w_drain_shift) begin
                    if (r_drain == PRE_C - ONE_C) begin
                        w_state_nxt     = FILL;
                        w_cnt_nxt       = '0;
                        w_row_start_nxt = 1'b1;
                        w_drain_nxt     = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_drain_nxt = r_drain + ONE_C;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = FILL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_short   <= 1'b0;
`ifdef SAD_FEEDER_ZERO_PAD_EN
            r_row_start <= 1'b1;
            r_drain     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_short   <= w_short_nxt;
`ifdef SAD_FEEDER_ZERO_PAD_EN
            r_row_start <= w_row_start_nxt;
            r_drain     <= w_drain_nxt;
`endif
        end
    end

    assign m_valid   = r_m_valid;
    assign short_row = r_short;

endmodule

// File: tb/tb_sad_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_sad_window_feeder
// Directed bench for sad_window_feeder with hand-built expected windows.
// ---------------------------------------------------------------------------
module tb_sad_window_feeder;
    import sad_pkg::*;

    localparam int WIN = WIN_DEF;
    localparam int BW  = DATA_SIZE_DEF * IMG_W_DEF;
    localparam int OW  = BW * WIN;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic [BW-1:0] s_data  = '0;
    logic          m_ready = 1'b1;
    logic          s_ready;
    logic          m_valid;
    logic          short_row;
    logic [OW-1:0] m_window;

    sad_window_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_window  (m_window),
        .short_row (short_row)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    endtask

    // Monitor state
    int            cyc = 0;
    int            last_acc_cyc = 0;
    logic [OW-1:0] got_q[$];
    int            got_cyc_q[$];
    int            short_cnt = 0;
    int            short_cyc = -1;
    int            vld_cycles = 0;
    int            rdy_lo_cycles = 0;
    bit            chk_stall = 0;
    bit            prev_stall = 0;
    logic [OW-1:0] prev_win = '0;
    int            rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got_q.push_back(m_window);
            got_cyc_q.push_back(cyc);
        end
        if (short_row) begin
            short_cnt++;
            short_cyc = cyc;
        end
        if (m_valid) vld_cycles++;
        if (!s_ready) rdy_lo_cycles++;
        if (chk_stall) begin
            chk("s_ready_rule", s_ready, !m_valid || m_ready);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_window", m_window, prev_win);
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_win   = m_window;
    end

    // m_ready pattern: 0 = always, 1 = one on / two off, 2 = held low
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                default: m_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [OW-1:0] mk_win(input int start);
        logic [OW-1:0] w;
        w = '0;
        for (int k = 0; k < WIN; k++) w[k*BW +: BW] = BW'(start + k);
        return w;
    endfunction

    function automatic logic [OW-1:0] mk_pad(input int first_slot, input int start, input int n);
        logic [OW-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[(first_slot+i)*BW +: BW] = BW'(start + i);
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int d, input logic last);
        bit acc;
        acc     = 0;
        s_valid = 1'b1;
        s_data  = BW'(d);
        s_last  = last;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("beat_timeout", 0, 1);
        last_acc_cyc = cyc;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_row(input int base, input int len);
        for (int i = 0; i < len; i++) send_beat(base + i, i == len - 1);
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_cyc_q.delete();
        short_cnt     = 0;
        short_cyc     = -1;
        vld_cycles    = 0;
        rdy_lo_cycles = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_window", m_window, 0);
        chk("rst_short_row", short_row, 0);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

`ifdef SAD_FEEDER_ZERO_PAD_EN
        // Row of 4: padded to 4 windows, DRAIN holds s_ready low
        clear_mon();
        send_row(1, 4);
        idle(12);
        chk("pad4_count", got_q.size(), 4);
        if (got_q.size() == 4)
            for (int w = 0; w < 4; w++) chk("pad4_win", got_q[w], mk_pad(7 - w, 1, 4));
        chk("pad4_drain_rdy_lo", rdy_lo_cycles, 7);
        chk("pad4_short", short_cnt, 0);

        // Row of 10 after a drained row: 10 windows
        clear_mon();
        send_row(20, 10);
        idle(12);
        chk("pad10_count", got_q.size(), 10);
        if (got_q.size() == 10) begin
            chk("pad10_first", got_q[0], mk_pad(7, 20, 8));
            chk("pad10_last", got_q[9], mk_pad(0, 22, 8));
        end
        chk("pad10_drain_rdy_lo", rdy_lo_cycles, 7);
`else
        // Test 1: exactly WIN beats -> one window, latency 1
        clear_mon();
        send_row(0, 15);
        idle(4);
        chk("t1_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("t1_win", got_q[0], mk_win(0));
            chk("t1_latency", got_cyc_q[0], last_acc_cyc);
        end
        chk("t1_valid_cycles", vld_cycles, 1);
        chk("t1_short", short_cnt, 0);

        // Test 2: 20 beats -> 6 windows in order
        clear_mon();
        send_row(0, 20);
        idle(4);
        chk("t2_count", got_q.size(), 6);
        if (got_q.size() == 6)
            for (int w = 0; w < 6; w++) chk("t2_win", got_q[w], mk_win(w));
        chk("t2_short", short_cnt, 0);

        // Test 3: same row with back-pressure
        clear_mon();
        rdy_mode  = 1;
        chk_stall = 1;
        send_row(0, 20);
        idle(30);
        chk_stall = 0;
        rdy_mode  = 0;
        idle(2);
        chk("t3_count", got_q.size(), 6);
        if (got_q.size() == 6)
            for (int w = 0; w < 6; w++) chk("t3_win", got_q[w], mk_win(w));
        chk("t3_stalled", rdy_lo_cycles > 0, 1);

        // Test 4: short row then a full row
        clear_mon();
        send_row(0, 10);
        idle(3);
        chk("t4_short_cnt", short_cnt, 1);
        chk("t4_short_time", short_cyc, last_acc_cyc);
        chk("t4_no_window", got_q.size(), 0);
        clear_mon();
        send_row(100, 15);
        idle(3);
        chk("t4_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("t4_win", got_q[0], mk_win(100));
        chk("t4_no_short", short_cnt, 0);

        // Test 5: reset with a pending window under back-pressure
        clear_mon();
        for (int i = 0; i < 17; i++) send_beat(i, 1'b0);
        rdy_mode = 2;
        @(negedge clk);
        chk("t5_pending", m_valid, 1);
        chk("t5_consumed", got_q.size(), 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rst_valid", m_valid, 0);
        chk("t5_rst_window", m_window, 0);
        chk("t5_rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        clear_mon();
        send_row(50, 15);
        idle(3);
        chk("t5_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("t5_win", got_q[0], mk_win(50));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
